// File: rtl/riscv_testutil_bus_arb.sv
// riscv_testutil_bus_arb
//
// Two-host to one-device bus arbiter for the RISC-V test harness. Host 0 is
// the core data port, host 1 is the signature reader. Requests are
// arbitrated round-robin and forwarded combinationally to a single device
// port. A small ID FIFO remembers which host owns each granted, unresponded
// transaction so that in-order device responses are routed back to the
// right host in the same cycle they arrive.
//
// Handshake: a device transfer happens on a cycle where dev_req_o &&
// dev_gnt_i. Once dev_req_o is raised for a host it stays pointed at that
// host (same address/data) until the device grants it. A response is one
// cycle of dev_rvalid_i and always belongs to the oldest outstanding grant.
//
// Ports
//   clk_i, rst_ni         clock (rising edge), async active-low reset
//   host_*_i / host_*_o   per-host request inputs, grant/response outputs
//   host_rdata_o          response data shared by both hosts
//   dev_*_o / dev_*_i     device request outputs, device grant/response
//   unexp_rsp_o           sticky: a response arrived with nothing outstanding
module riscv_testutil_bus_arb #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,

    input  logic [1:0]       host_req_i,
    input  logic [1:0]       host_we_i,
    input  logic [1:0][31:0] host_addr_i,
    input  logic [1:0][31:0] host_wdata_i,
    input  logic [1:0][3:0]  host_be_i,
    output logic [1:0]       host_gnt_o,
    output logic [1:0]       host_rvalid_o,
    output logic [31:0]      host_rdata_o,
    output logic [1:0]       host_err_o,

    output logic             dev_req_o,
    output logic             dev_we_o,
    output logic [31:0]      dev_addr_o,
    output logic [31:0]      dev_wdata_o,
    output logic [3:0]       dev_be_o,
    input  logic             dev_gnt_i,
    input  logic             dev_rvalid_i,
    input  logic             dev_err_i,
    input  logic [31:0]      dev_rdata_i,

    output logic             unexp_rsp_o
);

    localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CntW = $clog2(MaxOutstanding + 1);
    localparam logic [PtrW-1:0] PtrLast = PtrW'(MaxOutstanding - 1);
    localparam logic [CntW-1:0] CntFull = CntW'(MaxOutstanding);

    // Last-granted host; the other host wins on contention.
    logic                      prio_q, prio_d;
    // Selection lock: a raised but ungranted request keeps its host.
    logic                      lock_q, lock_d;
    logic                      lock_host_q, lock_host_d;
    // ID FIFO of granted host indices.
    logic [MaxOutstanding-1:0] id_q, id_d;
    logic [PtrW-1:0]           wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]           rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic                      unexp_q, unexp_d;

    logic sel;
    logic full;
    logic grant;
    logic pop;
    logic head;

    // Host selection and request path.
    always_comb begin
        full = (cnt_q == CntFull);
        if (lock_q) begin
            sel = lock_host_q;
        end else if (&host_req_i) begin
            sel = ~prio_q;
        end else begin
            sel = host_req_i[1];
        end

        // A full FIFO blocks the request even if a pop happens this cycle:
        // the count only drops at the next edge.
        dev_req_o   = host_req_i[sel] && !full;
        dev_we_o    = dev_req_o && host_we_i[sel];
        dev_addr_o  = dev_req_o ? host_addr_i[sel]  : '0;
        dev_wdata_o = dev_req_o ? host_wdata_i[sel] : '0;
        dev_be_o    = dev_req_o ? host_be_i[sel]    : '0;

        grant      = dev_req_o && dev_gnt_i;
        host_gnt_o = '0;
        if (grant) begin
            host_gnt_o[sel] = 1'b1;
        end
    end

    // Response routing to the head of the ID FIFO.
    always_comb begin
        head          = id_q[rd_ptr_q];
        pop           = dev_rvalid_i && (cnt_q != '0);
        host_rvalid_o = '0;
        host_err_o    = '0;
        if (pop) begin
            host_rvalid_o[head] = 1'b1;
            host_err_o[head]    = dev_err_i;
        end
        host_rdata_o = dev_rdata_i;
        unexp_rsp_o  = unexp_q;
    end

    // Next-state logic.
    always_comb begin
        prio_d      = grant ? sel : prio_q;
        lock_d      = dev_req_o && !dev_gnt_i;
        lock_host_d = sel;
        id_d        = id_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        cnt_d       = cnt_q;

        if (grant) begin
            id_d[wr_ptr_q] = sel;
            wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({grant, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        unexp_d = unexp_q || (dev_rvalid_i && (cnt_q == '0));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q      <= 1'b1;
            lock_q      <= 1'b0;
            lock_host_q <= 1'b0;
            id_q        <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            cnt_q       <= '0;
            unexp_q     <= 1'b0;
        end else begin
            prio_q      <= prio_d;
            lock_q      <= lock_d;
            lock_host_q <= lock_host_d;
            id_q        <= id_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            cnt_q       <= cnt_d;
            unexp_q     <= unexp_d;
        end
    end

endmodule

// File: tb/tb_riscv_testutil_bus_arb.sv
// Directed testbench for riscv_testutil_bus_arb (MaxOutstanding = 2).
module tb_riscv_testutil_bus_arb;

    // ---------------- clock / reset ----------------
    logic clk_i = 1'b0;
    logic rst_ni;
    always #5 clk_i = ~clk_i;

    logic [1:0]       host_req;
    logic [1:0]       host_we;
    logic [1:0][31:0] host_addr;
    logic [1:0][31:0] host_wdata;
    logic [1:0][3:0]  host_be;
    logic [1:0]       host_gnt_o;
    logic [1:0]       host_rvalid_o;
    logic [31:0]      host_rdata_o;
    logic [1:0]       host_err_o;
    logic             dev_req_o;
    logic             dev_we_o;
    logic [31:0]      dev_addr_o;
    logic [31:0]      dev_wdata_o;
    logic [3:0]       dev_be_o;
    logic             dev_gnt;
    logic             dev_rvalid;
    logic             dev_err;
    logic [31:0]      dev_rdata;
    logic             unexp_rsp_o;

    riscv_testutil_bus_arb #(.MaxOutstanding(2)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .host_req_i    (host_req),
        .host_we_i     (host_we),
        .host_addr_i   (host_addr),
        .host_wdata_i  (host_wdata),
        .host_be_i     (host_be),
        .host_gnt_o    (host_gnt_o),
        .host_rvalid_o (host_rvalid_o),
        .host_rdata_o  (host_rdata_o),
        .host_err_o    (host_err_o),
        .dev_req_o     (dev_req_o),
        .dev_we_o      (dev_we_o),
        .dev_addr_o    (dev_addr_o),
        .dev_wdata_o   (dev_wdata_o),
        .dev_be_o      (dev_be_o),
        .dev_gnt_i     (dev_gnt),
        .dev_rvalid_i  (dev_rvalid),
        .dev_err_i     (dev_err),
        .dev_rdata_i   (dev_rdata),
        .unexp_rsp_o   (unexp_rsp_o)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fails  = 0;
    logic [31:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        host_req   = '0;
        host_we    = '0;
        host_addr  = '0;
        host_wdata = '0;
        host_be    = '0;
        dev_gnt    = 1'b0;
        dev_rvalid = 1'b0;
        dev_err    = 1'b0;
        dev_rdata  = '0;
    endtask

    task automatic set_host(input int h, input logic req, input logic we,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be);
        host_req[h]   = req;
        host_we[h]    = we;
        host_addr[h]  = addr;
        host_wdata[h] = wdata;
        host_be[h]    = be;
    endtask

    task automatic set_dev(input logic gnt, input logic rvalid, input logic err,
                           input logic [31:0] rdata);
        dev_gnt    = gnt;
        dev_rvalid = rvalid;
        dev_err    = err;
        dev_rdata  = rdata;
    endtask

    // Drive point: 1 time unit after the rising edge. Checks follow #1 later.
    task automatic next_cycle();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int exp_host;
        logic [31:0] front;

        rst_ni = 1'b0;
        idle_inputs();
        #1;
        check_eq("rst_dev_req", 32'(dev_req_o), 32'd0);
        check_eq("rst_gnt", 32'(host_gnt_o), 32'd0);
        check_eq("rst_rvalid", 32'(host_rvalid_o), 32'd0);
        check_eq("rst_unexp", 32'(unexp_rsp_o), 32'd0);
        check_eq("rst_addr", dev_addr_o, 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Contention: grants alternate 0,1,0,1; responses follow grant order.
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            set_host(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0, 4'hF);
            set_host(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0, 4'hF);
            set_dev(1'b1, (i > 0), 1'b0, 32'h100 + 32'(i));
            #1;
            exp_host = i % 2;
            check_eq("rr_gnt", 32'(host_gnt_o), 32'(1) << exp_host);
            check_eq("rr_addr", dev_addr_o, (exp_host == 1) ? 32'h2000 : 32'h1000);
            if (i > 0) begin
                front = exp_q.pop_front();
                check_eq("rr_rvalid", 32'(host_rvalid_o), 32'(1) << front);
                check_eq("rr_rdata", host_rdata_o, 32'h100 + 32'(i));
            end
            exp_q.push_back(32'(exp_host));
        end
        next_cycle();
        idle_inputs();
        set_dev(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        front = exp_q.pop_front();
        check_eq("rr_last_gnt", 32'(host_gnt_o), 32'd0);
        check_eq("rr_last_rvalid", 32'(host_rvalid_o), 32'(1) << front);

        // Lock: host 1 waits ungranted; host 0 joins but must not steal it.
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            idle_inputs();
            set_host(1, 1'b1, 1'b1, 32'h0000_3000, 32'hDEAD_BEEF, 4'hF);
            #1;
            check_eq("lock_h1_req", 32'(dev_req_o), 32'd1);
            check_eq("lock_h1_addr", dev_addr_o, 32'h3000);
            check_eq("lock_h1_gnt", 32'(host_gnt_o), 32'd0);
        end
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            set_host(0, 1'b1, 1'b0, 32'h0000_4000, 32'h0000_0055, 4'h3);
            #1;
            check_eq("lock_hold_addr", dev_addr_o, 32'h3000);
            check_eq("lock_hold_we", 32'(dev_we_o), 32'd1);
        end
        next_cycle();
        dev_gnt = 1'b1;
        #1;
        check_eq("lock_grant", 32'(host_gnt_o), 32'b10);
        check_eq("lock_wdata", dev_wdata_o, 32'hDEAD_BEEF);
        check_eq("lock_be", 32'(dev_be_o), 32'hF);
        next_cycle();
        #1;
        check_eq("lock_next_gnt", 32'(host_gnt_o), 32'b01);
        check_eq("lock_next_addr", dev_addr_o, 32'h4000);
        check_eq("lock_next_be", 32'(dev_be_o), 32'h3);
        check_eq("lock_next_wdata", dev_wdata_o, 32'h55);
        next_cycle();
        idle_inputs();
        set_dev(1'b0, 1'b1, 1'b0, 32'h0);
        #1;
        check_eq("lock_rsp1", 32'(host_rvalid_o), 32'b10);
        next_cycle();
        #1;
        check_eq("lock_rsp2", 32'(host_rvalid_o), 32'b01);

        // Full FIFO: two grants block the third, even with a pop that cycle.
        next_cycle();
        idle_inputs();
        set_host(0, 1'b1, 1'b0, 32'h0000_5000, 32'h0, 4'hF);
        dev_gnt = 1'b1;
        #1;
        check_eq("full_g1", 32'(host_gnt_o), 32'b01);
        next_cycle();
        #1;
        check_eq("full_g2", 32'(host_gnt_o), 32'b01);
        next_cycle();
        #1;
        check_eq("full_blk_req", 32'(dev_req_o), 32'd0);
        check_eq("full_blk_gnt", 32'(host_gnt_o), 32'd0);
        check_eq("full_blk_addr", dev_addr_o, 32'd0);
        next_cycle();
        dev_rvalid = 1'b1;
        #1;
        check_eq("full_pop_req", 32'(dev_req_o), 32'd0);
        check_eq("full_pop_rvalid", 32'(host_rvalid_o), 32'b01);
        next_cycle();
        dev_rvalid = 1'b0;
        #1;
        check_eq("full_reassert", 32'(dev_req_o), 32'd1);
        check_eq("full_regrant", 32'(host_gnt_o), 32'b01);
        next_cycle();
        #1;
        check_eq("full_again", 32'(dev_req_o), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_cycle();
            idle_inputs();
            dev_rvalid = 1'b1;
            #1;
            check_eq("full_drain", 32'(host_rvalid_o), 32'b01);
        end

        // Ordering and error routing.
        next_cycle();
        idle_inputs();
        set_host(0, 1'b1, 1'b0, 32'h0000_6000, 32'h0, 4'hF);
        dev_gnt = 1'b1;
        #1;
        check_eq("ord_g0", 32'(host_gnt_o), 32'b01);
        next_cycle();
        idle_inputs();
        set_host(1, 1'b1, 1'b0, 32'h0000_7000, 32'h0, 4'hF);
        dev_gnt = 1'b1;
        #1;
        check_eq("ord_g1", 32'(host_gnt_o), 32'b10);
        next_cycle();
        idle_inputs();
        set_dev(1'b0, 1'b1, 1'b0, 32'h1111_1111);
        #1;
        check_eq("ord_rv0", 32'(host_rvalid_o), 32'b01);
        check_eq("ord_rd0", host_rdata_o, 32'h1111_1111);
        check_eq("ord_err0", 32'(host_err_o), 32'b00);
        next_cycle();
        set_dev(1'b0, 1'b1, 1'b1, 32'h2222_2222);
        #1;
        check_eq("ord_rv1", 32'(host_rvalid_o), 32'b10);
        check_eq("ord_rd1", host_rdata_o, 32'h2222_2222);
        check_eq("ord_err1", 32'(host_err_o), 32'b10);

        // Unexpected response with an empty FIFO.
        next_cycle();
        idle_inputs();
        #1;
        check_eq("unexp_before", 32'(unexp_rsp_o), 32'd0);
        next_cycle();
        dev_rvalid = 1'b1;
        #1;
        check_eq("unexp_rvalid", 32'(host_rvalid_o), 32'b00);
        next_cycle();
        dev_rvalid = 1'b0;
        #1;
        check_eq("unexp_set", 32'(unexp_rsp_o), 32'd1);
        next_cycle();
        set_host(0, 1'b1, 1'b0, 32'h0000_8000, 32'h0, 4'hF);
        dev_gnt = 1'b1;
        #1;
        check_eq("unexp_cnt_gnt", 32'(host_gnt_o), 32'b01);
        next_cycle();
        idle_inputs();
        dev_rvalid = 1'b1;
        #1;
        check_eq("unexp_cnt_rsp", 32'(host_rvalid_o), 32'b01);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("unexp_held", 32'(unexp_rsp_o), 32'd1);

        // Mid-operation reset with two outstanding (last grant host 0).
        next_cycle();
        set_host(1, 1'b1, 1'b0, 32'h0000_9000, 32'h0, 4'hF);
        dev_gnt = 1'b1;
        #1;
        check_eq("mid_g1", 32'(host_gnt_o), 32'b10);
        next_cycle();
        idle_inputs();
        set_host(0, 1'b1, 1'b0, 32'h0000_A000, 32'h0, 4'hF);
        dev_gnt = 1'b1;
        #1;
        check_eq("mid_g0", 32'(host_gnt_o), 32'b01);
        next_cycle();
        set_host(1, 1'b1, 1'b0, 32'h0000_9000, 32'h0, 4'hF);
        #1;
        check_eq("mid_full", 32'(dev_req_o), 32'd0);
        #2;
        rst_ni = 1'b0;
        idle_inputs();
        #1;
        check_eq("mid_rst_req", 32'(dev_req_o), 32'd0);
        check_eq("mid_rst_unexp", 32'(unexp_rsp_o), 32'd0);
        check_eq("mid_rst_rvalid", 32'(host_rvalid_o), 32'd0);
        check_eq("mid_rst_gnt", 32'(host_gnt_o), 32'd0);
        @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        next_cycle();
        set_host(0, 1'b1, 1'b0, 32'h0000_B000, 32'h0, 4'hF);
        set_host(1, 1'b1, 1'b0, 32'h0000_C000, 32'h0, 4'hF);
        dev_gnt = 1'b1;
        #1;
        check_eq("post_rst_gnt", 32'(host_gnt_o), 32'b01);
        check_eq("post_rst_addr", dev_addr_o, 32'hB000);
        next_cycle();
        idle_inputs();
        dev_rvalid = 1'b1;
        #1;
        check_eq("post_rst_rsp", 32'(host_rvalid_o), 32'b01);
        next_cycle();
        #1;
        check_eq("post_rst_stale", 32'(host_rvalid_o), 32'b00);
        next_cycle();
        idle_inputs();
        #1;
        check_eq("post_rst_unexp", 32'(unexp_rsp_o), 32'd1);

        // ---------------- report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/riscv_testutil_bus_arb.md
RISCV_TESTUTIL_BUS_ARB -- requirements
Module: riscv_testutil_bus_arb

Interface
REQ-001 SHALL have parameter MaxOutstanding, default 2, meaning the maximum number of granted, unresponded device transactions (legal range 1..4).
REQ-002 SHALL have clk_i  input  1  clock, rising-edge active.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have host_req_i  input  2  per-host request; host 0 is the core data port, host 1 is the signature reader.
REQ-005 SHALL have host_we_i  input  2  per-host write enable.
REQ-006 SHALL have host_addr_i  input  2x32  per-host byte address.
REQ-007 SHALL have host_wdata_i  input  2x32  per-host write data.
REQ-008 SHALL have host_be_i  input  2x4  per-host byte enables.
REQ-009 SHALL have host_gnt_o  output  2  per-host grant.
REQ-010 SHALL have host_rvalid_o  output  2  per-host response valid.
REQ-011 SHALL have host_rdata_o  output  32  response data, shared by both hosts and qualified by host_rvalid_o.
REQ-012 SHALL have host_err_o  output  2  per-host response error.
REQ-013 SHALL have dev_req_o, dev_we_o (1 bit each), dev_addr_o, dev_wdata_o (32 bits each) and dev_be_o (4 bits), all outputs forming the device request.
REQ-014 SHALL have dev_gnt_i, dev_rvalid_i, dev_err_i (1 bit each) and dev_rdata_i (32 bits), all inputs forming the device response.
REQ-015 SHALL have unexp_rsp_o  output  1  sticky flag: a device response arrived with nothing outstanding.

Function
REQ-016 Arbitration SHALL be round-robin.
- Priority pointer holds the last-granted host.
- The other host has priority on contention.
- The pointer updates only on a cycle where dev_req_o && dev_gnt_i.
REQ-017 Selection lock: once dev_req_o asserts for host X without dev_gnt_i, the block SHALL keep selecting X every cycle until granted, regardless of the other host's requests.
REQ-018 Request path SHALL be combinational: dev_req_o/we/addr/wdata/be equal the selected host's inputs.
REQ-019 Grant routing SHALL be combinational: host_gnt_o[X] = dev_gnt_i && dev_req_o && selected==X; the unselected host's grant SHALL be 0.
REQ-020 An ID FIFO of depth MaxOutstanding SHALL store the granted host index.
- Push on every device grant.
- Pop on every dev_rvalid_i.
REQ-021 When the FIFO count equals MaxOutstanding, dev_req_o SHALL be 0, even if a pop occurs in the same cycle.
REQ-022 Responses SHALL be in order, combinational, same cycle.
- host_rvalid_o[head] = dev_rvalid_i.
- host_err_o[head] = dev_err_i.
- host_rdata_o = dev_rdata_i.
REQ-023 A simultaneous push and pop SHALL leave the count unchanged.
- The pop SHALL route to the old head.
- Read/write pointers SHALL wrap modulo MaxOutstanding.
REQ-024 dev_rvalid_i with an empty FIFO SHALL:
- assert no host_rvalid_o;
- not change the count;
- set unexp_rsp_o, which stays 1 until reset.
REQ-025 When neither host requests or the FIFO is full, dev_* request outputs other than dev_req_o SHALL be 0.

Reset
REQ-026 Asynchronous assertion of rst_ni SHALL:
- clear the FIFO count and pointers;
- clear the selection lock and unexp_rsp_o;
- set the priority pointer to host 1, so host 0 wins first contention.
REQ-027 During and after reset, all outputs SHALL be 0 until a request arrives; outstanding responses lost mid-operation SHALL be treated per REQ-024.

Verification
REQ-028 Contention: both hosts request continuously with dev_gnt_i=1 and single-cycle rvalid -> grants alternate 0,1,0,1; each response is routed to the matching host.
REQ-029 Lock: host 1 requests with dev_gnt_i=0 for 3 cycles, then host 0 raises its request -> dev_addr_o stays host 1's address until the grant; host 0 is granted next.
REQ-030 Full FIFO: MaxOutstanding=2, two grants with no rvalid -> dev_req_o=0 the next cycle; it reasserts the cycle after the first rvalid; a pop in the full cycle still blocks the grant.
REQ-031 Ordering: grants 0,1 are followed by rvalid with rdata 0x11111111 then 0x22222222 -> host 0 receives 0x11111111 and host 1 receives 0x22222222; dev_err_i=1 on the second response -> host_err_o=2'b10.
REQ-032 Unexpected response: dev_rvalid_i=1 after reset with nothing outstanding -> host_rvalid_o=0 and unexp_rsp_o=1 and held; it clears only on rst_ni.
REQ-033 Mid-operation reset: rst_ni asserted with 2 outstanding -> count is 0 and outputs are 0; the first host 0 request after release is granted when contending with host 1.
